// File: rtl/shift_row.sv
// AES-128 ShiftRows stage with a one-cycle output register.
// Optional InvShiftRows selection is built when SHIFT_ROW_INV_EN is defined.
module shift_row (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] in,
  input  logic         in_valid,
  input  logic         inv,
  output logic [127:0] out,
  output logic         out_valid
);

  // Byte k sits at in[127-8k -: 8]; state is column-major, s[r][c] = byte 4c+r.
  function automatic logic [127:0] perm_fwd(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c+rw)%4)+rw) -: 8];
      end
    end
    return r;
  endfunction

`ifdef SHIFT_ROW_INV_EN
  function automatic logic [127:0] perm_inv(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[127-8*(4*c+rw) -: 8] = s[127-8*(4*((c-rw+4)%4)+rw) -: 8];
      end
    end
    return r;
  endfunction
`endif

  logic [127:0] shifted;

`ifdef SHIFT_ROW_INV_EN
  always_comb begin
    shifted = inv ? perm_inv(in) : perm_fwd(in);
  end
`else
  // Port kept for interface stability; only the forward permutation exists.
  logic unused_inv;
  assign unused_inv = inv;

  always_comb begin
    shifted = perm_fwd(in);
  end
`endif

  // Valid/ready: no ready; out_valid pulses for exactly one cycle per accepted
  // in_valid, and out holds its last value whenever no new state is captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out <= shifted;
      end
    end
  end

endmodule

// File: tb/tb_shift_row.sv
// Bench for shift_row: row-rotation reference model, per-cycle compare, and
// directed literal vectors.
module tb_shift_row;

  logic         clk;
  logic         rst_n;
  logic [127:0] in;
  logic         in_valid;
  logic         inv;
  logic [127:0] out;
  logic         out_valid;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_q[$];
  logic [127:0] m_out;
  logic         m_valid;
  logic         live = 1'b0;
  logic         done = 1'b0;

  shift_row dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .in_valid  (in_valid),
    .inv       (inv),
    .out       (out),
    .out_valid (out_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unpack to a 4x4 matrix, rotate row r by r single steps.
  function automatic logic [127:0] model(input logic [127:0] s, input logic iv);
    logic [7:0]   m[4][4];
    logic [7:0]   t;
    logic [127:0] r;
    for (int k = 0; k < 16; k++) m[k%4][k/4] = s[127-8*k -: 8];
    for (int rw = 1; rw < 4; rw++) begin
      for (int n = 0; n < rw; n++) begin
        if (!iv) begin
          t = m[rw][0];
          m[rw][0] = m[rw][1]; m[rw][1] = m[rw][2]; m[rw][2] = m[rw][3];
          m[rw][3] = t;
        end else begin
          t = m[rw][3];
          m[rw][3] = m[rw][2]; m[rw][2] = m[rw][1]; m[rw][1] = m[rw][0];
          m[rw][0] = t;
        end
      end
    end
    r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = m[k%4][k/4];
    return r;
  endfunction

  function automatic logic eff_inv(input logic i);
`ifdef SHIFT_ROW_INV_EN
    return i;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // model registers, updated on the same edge the DUT captures
  always @(posedge clk) begin
    if (!rst_n) begin
      m_out   = '0;
      m_valid = 1'b0;
      exp_q.delete();
      live    = 1'b1;
    end else begin
      m_valid = in_valid;
      if (in_valid) begin
        m_out = model(in, eff_inv(inv));
        exp_q.push_back(m_out);
      end
    end
  end

  // scoreboard compare on the opposite edge
  always @(negedge clk) begin
    if (live && !done) begin
      check("cyc_valid", {127'd0, out_valid}, {127'd0, m_valid});
      check("cyc_out", out, m_out);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 128'd1, 128'd0);
        end else begin
          check("sb_out", out, exp_q.pop_front());
        end
      end
    end
  end

  // driver: change inputs at negedge, return 1 time unit after the capturing edge
  task automatic drive(input logic v, input logic [127:0] d, input logic i);
    @(negedge clk);
    in_valid = v;
    in       = d;
    inv      = i;
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] V_IN   = 128'h5a2c6d7e9f0b15b3c6d5a8f5c9d4a1a6;
  localparam logic [127:0] V_OUT  = 128'h5a0ba8a69fd5a17ec6d46db3c92c15f5;
  localparam logic [127:0] ID_IN  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ID_OUT = 128'h00050a0f04090e03080d02070c01060b;

  initial begin
    logic [127:0] r3_in[4];
    logic [127:0] r3_out[4];
    logic [127:0] inv_exp;
    logic [127:0] rnd;

    r3_in[0]  = V_IN;
    r3_in[1]  = {V_IN[127:8], 8'ha5};
    r3_in[2]  = {V_IN[127:8], 8'ha4};
    r3_in[3]  = {V_IN[127:8], 8'ha3};
    r3_out[0] = 128'h5a0ba8a69fd5a17ec6d46db3c92c15f5;
    r3_out[1] = 128'h5a0ba8a59fd5a17ec6d46db3c92c15f5;
    r3_out[2] = 128'h5a0ba8a49fd5a17ec6d46db3c92c15f5;
    r3_out[3] = 128'h5a0ba8a39fd5a17ec6d46db3c92c15f5;

    // pin the model to hand-computed values
    check("model_fwd", model(V_IN, 1'b0), V_OUT);
    check("model_id", model(ID_IN, 1'b0), ID_OUT);
    check("model_inv", model(V_OUT, 1'b1), V_IN);

    // reset held 2 cycles with valid all-ones input
    rst_n = 1'b0; in_valid = 1'b1; in = '1; inv = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(posedge clk); #1;
      check("rst_out", out, 128'd0);
      check("rst_valid", {127'd0, out_valid}, 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;

    drive(1'b1, V_IN, 1'b0);
    check("fwd_out", out, V_OUT);
    check("fwd_valid", {127'd0, out_valid}, 128'd1);

    // back-to-back row-3 rotation
    for (int n = 0; n < 4; n++) begin
      drive(1'b1, r3_in[n], 1'b0);
      check($sformatf("row3_%0d", n), out, r3_out[n]);
      check($sformatf("row3_valid_%0d", n), {127'd0, out_valid}, 128'd1);
    end

    drive(1'b1, ID_IN, 1'b0);
    check("ident_out", out, ID_OUT);

`ifdef SHIFT_ROW_INV_EN
    inv_exp = V_IN;
`else
    inv_exp = model(V_OUT, 1'b0);
`endif
    drive(1'b1, V_OUT, 1'b1);
    check("inv_out", out, inv_exp);

    // hold: in_valid low with different data
    drive(1'b0, ID_IN, 1'b0);
    check("hold_out", out, inv_exp);
    check("hold_valid", {127'd0, out_valid}, 128'd0);

    // a few extra states with mixed inv for the per-cycle model check
    for (int n = 0; n < 8; n++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      drive(1'b1, rnd, 1'($urandom_range(0, 1)));
    end

    // reset priority over in_valid
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; in = V_IN; inv = 1'b0;
    @(posedge clk); #1;
    check("rstpri_out", out, 128'd0);
    check("rstpri_valid", {127'd0, out_valid}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_valid", {127'd0, out_valid}, 128'd0);
    check("post_rst_out", out, 128'd0);

    drive(1'b1, ID_IN, 1'b0);
    check("fresh_out", out, ID_OUT);
    drive(1'b0, '0, 1'b0);

    @(negedge clk);
    done = 1'b1;
    if (exp_q.size() != 0) check("sb_leftover", 128'(exp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
